// File: rtl/registerfile_sc.sv
// registerfile_sc: 2-read/1-write register file with a synchronous clear sweep.
// Storage has no per-flop reset; a sweep FSM writes zeros to every entry.
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   Read1, Read2          - read addresses (A bits)
//   WriteReg, WriteData   - write address / data
//   RegWrite              - write enable (ignored while Busy)
//   Clear                 - start a clear sweep (only from idle)
//   Data1, Data2          - combinational read data (0 while Busy)
//   Busy                  - registered, high while the sweep runs
module registerfile_sc #(
    parameter int W        = 32,
    parameter int A        = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [A-1:0] Read1,
    input  logic [A-1:0] Read2,
    input  logic [A-1:0] WriteReg,
    input  logic [W-1:0] WriteData,
    input  logic         RegWrite,
    input  logic         Clear,
    output logic [W-1:0] Data1,
    output logic [W-1:0] Data2,
    output logic         Busy
);

    localparam int N = 1 << A;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t         r_state;
    logic [A-1:0]   r_idx;
    logic [W-1:0]   r_mem [N];

    state_t         w_state_nxt;
    logic [A-1:0]   w_idx_nxt;
    logic           w_we;
    logic [A-1:0]   w_waddr;
    logic [W-1:0]   w_wdata;
    logic           w_busy;
    logic           w_wr_zero;

    assign w_busy    = (r_state == S_CLEAR);
    assign w_wr_zero = (ZERO_REG != 0) && (WriteReg == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Array has no reset so it can map onto RAM.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_we        = 1'b0;
        w_waddr     = WriteReg;
        w_wdata     = WriteData;
        unique case (r_state)
            S_IDLE: begin
                if (Clear) begin
                    // Same-cycle RegWrite is dropped on purpose.
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end else if (RegWrite && !w_wr_zero) begin
                    w_we = 1'b1;
                end
            end
            S_CLEAR: begin
                w_we      = 1'b1;
                w_waddr   = r_idx;
                w_wdata   = '0;
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == {A{1'b1}}) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Reset edge restarts the sweep without touching the array.
        if (reset) begin
            w_we = 1'b0;
        end
    end

    always_comb begin
        Data1 = r_mem[Read1];
        if (w_busy) begin
            Data1 = '0;
        end else if ((ZERO_REG != 0) && (Read1 == '0)) begin
            Data1 = '0;
        end else if ((BYPASS != 0) && RegWrite && (WriteReg == Read1)) begin
            Data1 = WriteData;
        end
    end

    always_comb begin
        Data2 = r_mem[Read2];
        if (w_busy) begin
            Data2 = '0;
        end else if ((ZERO_REG != 0) && (Read2 == '0)) begin
            Data2 = '0;
        end else if ((BYPASS != 0) && RegWrite && (WriteReg == Read2)) begin
            Data2 = WriteData;
        end
    end

    assign Busy = w_busy;

endmodule

// File: tb/tb_registerfile_sc.sv
// tb_registerfile_sc: directed checks of registerfile_sc with bypass,
// without bypass, and at W=8/A=3.
module tb_registerfile_sc;

    logic        clk = 1'b0;
    logic        rst, rw, clr;
    logic [4:0]  r1, r2, wreg;
    logic [31:0] wdata;
    logic [31:0] d0_1, d0_2, d1_1, d1_2;
    logic        d0_b, d1_b;

    logic        rst2, rw2, clr2;
    logic [2:0]  r12, r22, wreg2;
    logic [7:0]  wdata2, d2_1, d2_2;
    logic        d2_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    registerfile_sc #(.W(32), .A(5), .ZERO_REG(1), .BYPASS(1)) u_d0 (
        .clock(clk), .reset(rst), .Read1(r1), .Read2(r2),
        .WriteReg(wreg), .WriteData(wdata), .RegWrite(rw), .Clear(clr),
        .Data1(d0_1), .Data2(d0_2), .Busy(d0_b)
    );

    registerfile_sc #(.W(32), .A(5), .ZERO_REG(1), .BYPASS(0)) u_d1 (
        .clock(clk), .reset(rst), .Read1(r1), .Read2(r2),
        .WriteReg(wreg), .WriteData(wdata), .RegWrite(rw), .Clear(clr),
        .Data1(d1_1), .Data2(d1_2), .Busy(d1_b)
    );

    registerfile_sc #(.W(8), .A(3), .ZERO_REG(1), .BYPASS(1)) u_d2 (
        .clock(clk), .reset(rst2), .Read1(r12), .Read2(r22),
        .WriteReg(wreg2), .WriteData(wdata2), .RegWrite(rw2), .Clear(clr2),
        .Data1(d2_1), .Data2(d2_2), .Busy(d2_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e2nb;
    } vec_t;

    vec_t vt[11];

    initial begin
        int n;
        int n2;
        bit z;

        vt[0]  = '{1'b1, 5'd7,  32'h0000_1234, 5'd7,  5'd7,
                   32'h0000_1234, 32'h0000_1234, 32'h0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,
                   32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
        vt[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,
                   32'h0, 32'h0, 32'h0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd3,
                   32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[4]  = '{1'b1, 5'd5,  32'hA5A5_A5A5, 5'd1,  5'd5,
                   32'h0, 32'hA5A5_A5A5, 32'h0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,
                   32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vt[6]  = '{1'b1, 5'd5,  32'h5A5A_5A5A, 5'd5,  5'd5,
                   32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hA5A5_A5A5};
        vt[7]  = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30,
                   32'hCAFE_F00D, 32'h0, 32'h0};
        vt[8]  = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd5,
                   32'hCAFE_F00D, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
        vt[9]  = '{1'b1, 5'd6,  32'h0000_0001, 5'd6,  5'd6,
                   32'h1, 32'h1, 32'h0};
        vt[10] = '{1'b0, 5'd0,  32'h0,         5'd6,  5'd0,
                   32'h1, 32'h0, 32'h0};

        rst = 1'b1; clr = 1'b0; rw = 1'b1; wreg = 5'd3;
        wdata = 32'hDEAD_BEEF; r1 = 5'd3; r2 = 5'd3;
        rst2 = 1'b0; clr2 = 1'b0; rw2 = 1'b0; wreg2 = '0;
        wdata2 = '0; r12 = '0; r22 = '0;

        // Reset sweep with a write held on entry 3.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", {31'b0, d0_b}, 32'h1);
        chk("reset_data1", d0_1, 32'h0);
        n = 0; z = 1'b1;
        while (d0_b === 1'b1 && n < 100) begin
            n++;
            if (d0_1 !== '0 || d0_2 !== '0 || d1_1 !== '0) z = 1'b0;
            @(negedge clk);
            #1;
        end
        chk("reset_busy_len", n, 32);
        chk("reset_data_zero", {31'b0, z}, 32'h1);
        chk("busy_write_dropped", d1_1, 32'h0);
        chk("first_write_bypass", d0_1, 32'hDEAD_BEEF);
        @(negedge clk);
        rw = 1'b0;
        #1;
        chk("first_write_lands", d1_1, 32'hDEAD_BEEF);

        // Table of idle read/write/bypass vectors.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rw = vt[i].rw; wreg = vt[i].wreg; wdata = vt[i].wdata;
            r1 = vt[i].r1; r2 = vt[i].r2;
            #1;
            chk($sformatf("vec%0d_d1", i), d0_1, vt[i].e1);
            chk($sformatf("vec%0d_d2", i), d0_2, vt[i].e2);
            chk($sformatf("vec%0d_d2_nobyp", i), d1_2, vt[i].e2nb);
        end
        @(negedge clk);
        rw = 1'b0;

        // Fill 1..31 with index*3.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            rw = 1'b1; wreg = 5'(i); wdata = 32'(i * 3);
        end
        @(negedge clk);
        rw = 1'b0; r1 = 5'd9; r2 = 5'd31;
        #1;
        chk("fill_e9", d0_1, 32'd27);
        chk("fill_e31", d0_2, 32'd93);

        // Clear with a colliding write, second Clear mid-sweep.
        @(negedge clk);
        clr = 1'b1; rw = 1'b1; wreg = 5'd9; wdata = 32'h999;
        @(negedge clk);
        clr = 1'b0; rw = 1'b0; r1 = 5'd9; r2 = 5'd9;
        #1;
        n = 0; z = 1'b1;
        while (d0_b === 1'b1 && n < 100) begin
            n++;
            if (d0_1 !== '0 || d0_2 !== '0) z = 1'b0;
            @(negedge clk);
            clr = (n == 10);
            #1;
        end
        clr = 1'b0;
        chk("clear_busy_len", n, 32);
        chk("clear_data_zero", {31'b0, z}, 32'h1);
        z = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r1 = 5'(i); r2 = 5'(i);
            #1;
            if (d0_1 !== '0 || d1_2 !== '0) z = 1'b0;
        end
        chk("clear_all_zero", {31'b0, z}, 32'h1);
        r1 = 5'd9;
        #1;
        chk("clear_e9_dropped", d1_1, 32'h0);

        // Reset in mid-sweep, held 5 cycles.
        @(negedge clk);
        rw = 1'b1; wreg = 5'd20; wdata = 32'h20;
        @(negedge clk);
        rw = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        n = 0;
        while (d0_b === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("pre_reset_busy", {31'b0, d0_b}, 32'h1);
        rst = 1'b1;
        z = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (d0_b !== 1'b1 || d0_1 !== '0) z = 1'b0;
        end
        chk("reset_hold_busy", {31'b0, z}, 32'h1);
        rst = 1'b0;
        r1 = 5'd20;
        n = 0;
        while (d0_b === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("restart_busy_len", n, 32);
        chk("restart_e20_zero", d1_1, 32'h0);

        // Small instance: W=8, A=3.
        @(negedge clk);
        rst2 = 1'b1; rw2 = 1'b1; wreg2 = 3'd3; wdata2 = 8'hBE; r12 = 3'd3;
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        n2 = 0; z = 1'b1;
        while (d2_b === 1'b1 && n2 < 100) begin
            n2++;
            if (d2_1 !== '0) z = 1'b0;
            @(negedge clk);
            #1;
        end
        chk("p_busy_len", n2, 8);
        chk("p_data_zero", {31'b0, z}, 32'h1);
        chk("p_first_bypass", {24'b0, d2_1}, 32'hBE);
        @(negedge clk);
        rw2 = 1'b0;
        #1;
        chk("p_first_lands", {24'b0, d2_1}, 32'hBE);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rw2 = 1'b1; wreg2 = 3'(i); wdata2 = 8'(8'h10 + i);
        end
        @(negedge clk);
        rw2 = 1'b0; r12 = 3'd0; r22 = 3'd7;
        #1;
        chk("p_e0_zero", {24'b0, d2_1}, 32'h0);
        chk("p_e7", {24'b0, d2_2}, 32'h17);
        r12 = 3'd1; r22 = 3'd6;
        #1;
        chk("p_e1", {24'b0, d2_1}, 32'h11);
        chk("p_e6", {24'b0, d2_2}, 32'h16);
        @(negedge clk);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0; r12 = 3'd7;
        #1;
        n2 = 0;
        while (d2_b === 1'b1 && n2 < 100) begin
            n2++;
            @(negedge clk);
            #1;
        end
        chk("p_clear_len", n2, 8);
        chk("p_clear_e7", {24'b0, d2_1}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
